// File: rtl/cordic_iter_sequencer.sv
// Iteration controller for the CORDIC coprocessor: walks the arctangent ROM
// through 0..ITER-1, launches one datapath op per iteration and watches for a stalled datapath.
module cordic_iter_sequencer #(
    parameter int ITER = 24,
    parameter int TMO  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beg_fsm,
    input  logic       op_done,
    input  logic       sign_z,
    output logic       rom_enable,
    output logic [4:0] rom_address,
    output logic [4:0] shift_amt,
    output logic       op_start,
    output logic       dir,
    output logic       busy,
    output logic       done,
    output logic       tmo_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ROM_REQ  = 3'd1,
        S_ROM_WAIT = 3'd2,
        S_OP_ISSUE = 3'd3,
        S_OP_WAIT  = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(ITER - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t     state_q;
    logic [4:0] i_q;
    logic [7:0] wd_q;
    logic       rom_en_q;
    logic       op_start_q;
    logic       dir_q;
    logic       busy_q;
    logic       done_q;
    logic       tmo_q;

    // Outputs are registered alongside the state: each is set on the edge that
    // enters the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= 5'd0;
            wd_q       <= 8'd0;
            rom_en_q   <= 1'b0;
            op_start_q <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            op_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (beg_fsm) begin
                        state_q  <= S_ROM_REQ;
                        i_q      <= 5'd0;
                        tmo_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        rom_en_q <= 1'b1;
                    end
                end
                S_ROM_REQ: state_q <= S_ROM_WAIT;
                S_ROM_WAIT: begin
                    state_q    <= S_OP_ISSUE;
                    op_start_q <= 1'b1;
                end
                S_OP_ISSUE: begin
                    state_q <= S_OP_WAIT;
                    dir_q   <= ~sign_z;
                    wd_q    <= 8'd0;
                end
                S_OP_WAIT: begin
                    // op_done on the last allowed cycle still wins over the watchdog.
                    if (op_done) begin
                        state_q <= S_NEXT;
                    end else if (wd_q == TMO_LAST) begin
                        state_q  <= S_DONE;
                        tmo_q    <= 1'b1;
                        rom_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (i_q == LAST_IDX) begin
                        state_q  <= S_DONE;
                        rom_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        i_q     <= i_q + 5'd1;
                        state_q <= S_ROM_REQ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    i_q     <= 5'd0;
                    dir_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_enable  = rom_en_q;
    assign rom_address = i_q;
    assign shift_amt   = i_q;
    assign op_start    = op_start_q;
    assign dir         = dir_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tmo_err     = tmo_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Directed bench for cordic_iter_sequencer: three instances (ITER=4/TMO=3,
// ITER=32/TMO=63, ITER=1/TMO=3) exercised by scenario tasks with hand-derived cycle expectations.
`timescale 1ns/1ps
module tb_cordic_iter_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic beg_a, beg_b, beg_c;
    logic op_done, sign_z;

    logic       en_a, ops_a, dir_a, busy_a, done_a, tmo_a;
    logic [4:0] addr_a, sh_a;
    logic [2:0] st_a;
    logic       en_b, ops_b, dir_b, busy_b, done_b, tmo_b;
    logic [4:0] addr_b, sh_b;
    logic [2:0] st_b;
    logic       en_c, ops_c, dir_c, busy_c, done_c, tmo_c;
    logic [4:0] addr_c, sh_c;
    logic [2:0] st_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed view: {rom_enable, rom_address, shift_amt, op_start, busy, done, tmo_err}
    wire [14:0] obs_a = {en_a, addr_a, sh_a, ops_a, busy_a, done_a, tmo_a};
    wire [14:0] obs_b = {en_b, addr_b, sh_b, ops_b, busy_b, done_b, tmo_b};
    wire [14:0] obs_c = {en_c, addr_c, sh_c, ops_c, busy_c, done_c, tmo_c};

    cordic_iter_sequencer #(.ITER(4), .TMO(3)) u_a (
        .clk(clk), .rst(rst), .beg_fsm(beg_a), .op_done(op_done), .sign_z(sign_z),
        .rom_enable(en_a), .rom_address(addr_a), .shift_amt(sh_a), .op_start(ops_a),
        .dir(dir_a), .busy(busy_a), .done(done_a), .tmo_err(tmo_a), .state_dbg(st_a)
    );

    cordic_iter_sequencer #(.ITER(32), .TMO(63)) u_b (
        .clk(clk), .rst(rst), .beg_fsm(beg_b), .op_done(op_done), .sign_z(sign_z),
        .rom_enable(en_b), .rom_address(addr_b), .shift_amt(sh_b), .op_start(ops_b),
        .dir(dir_b), .busy(busy_b), .done(done_b), .tmo_err(tmo_b), .state_dbg(st_b)
    );

    cordic_iter_sequencer #(.ITER(1), .TMO(3)) u_c (
        .clk(clk), .rst(rst), .beg_fsm(beg_c), .op_done(op_done), .sign_z(sign_z),
        .rom_enable(en_c), .rom_address(addr_c), .shift_amt(sh_c), .op_start(ops_c),
        .dir(dir_c), .busy(busy_c), .done(done_c), .tmo_err(tmo_c), .state_dbg(st_c)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; beg_a = 1'b1; beg_b = 1'b1; beg_c = 1'b1;
        op_done = 1'b1; sign_z = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            n_checks++;
            if ({obs_a, dir_a} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_a cyc%0d: got %h expected 0000", n, {obs_a, dir_a});
            end
            n_checks++;
            if ({obs_b, dir_b} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_b cyc%0d: got %h expected 0000", n, {obs_b, dir_b});
            end
            n_checks++;
            if ({obs_c, dir_c} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_c cyc%0d: got %h expected 0000", n, {obs_c, dir_c});
            end
        end
        rst = 1'b0; beg_a = 1'b0; beg_b = 1'b0; beg_c = 1'b0;
        op_done = 1'b0; sign_z = 1'b0;
        step();
    endtask

    // Full ITER=4 run with k=1. s[n] is sign_z during iteration n. Optionally
    // holds beg_fsm high through the DONE cycle and adds stray op_done in ROM_WAIT.
    task automatic run_a(input string name, input logic [3:0] s, input bit hold_beg, input bit stray);
        logic [14:0] exp_v;
        logic [14:0] msk;
        logic        exp_dir;
        int          it, ph;
        beg_a = 1'b1; op_done = 1'b0; sign_z = s[0];
        step();
        for (int c = 1; c <= 22; c++) begin
            it = (c - 1) / 5;
            ph = (c - 1) % 5;
            beg_a   = hold_beg && (c <= 21);
            op_done = (ph == 3) || (stray && ph == 1);
            if (it < 4) sign_z = s[it];
            msk = '1;
            if (c <= 20) begin
                exp_v = {1'b1, 5'(it), 5'(it), (ph == 2), 1'b1, 1'b0, 1'b0};
            end else if (c == 21) begin
                exp_v = 15'b0_00000_00000_0_1_1_0;
                msk   = 15'b1_00000_00000_1_1_1_1;
            end else begin
                exp_v = 15'h0;
            end
            n_checks++;
            if ((obs_a & msk) !== (exp_v & msk)) begin
                n_fail++;
                $display("FAIL %s cyc%0d outputs: got %b expected %b (mask %b)", name, c, obs_a, exp_v, msk);
            end
            if (c <= 20 && (ph >= 3 || it > 0)) begin
                exp_dir = (ph >= 3) ? ~s[it] : ~s[it - 1];
                n_checks++;
                if (dir_a !== exp_dir) begin
                    n_fail++;
                    $display("FAIL %s_dir cyc%0d: got %b expected %b", name, c, dir_a, exp_dir);
                end
            end
            step();
        end
        beg_a = 1'b0; op_done = 1'b0;
    endtask

    task automatic test_nominal();
        run_a("nominal", 4'b0110, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_a("ignored", 4'b0101, 1'b1, 1'b1);
    endtask

    // Iteration 2 (cycles 6..) never sees op_done: OP_WAIT in 9,10,11, DONE in 12.
    task automatic test_timeout();
        int done_cyc;
        beg_a = 1'b1; op_done = 1'b0; sign_z = 1'b0;
        step();
        for (int c = 1; c <= 13; c++) begin
            beg_a   = 1'b0;
            op_done = (c == 4);
            if (c == 11) begin
                n_checks++;
                if ({en_a, busy_a, tmo_a} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL tmo_last_wait: got %b expected 110", {en_a, busy_a, tmo_a});
                end
            end
            if (c == 12) begin
                n_checks++;
                if ({en_a, busy_a, done_a, tmo_a} !== 4'b0111) begin
                    n_fail++;
                    $display("FAIL tmo_done: got %b expected 0111", {en_a, busy_a, done_a, tmo_a});
                end
            end
            if (c == 13) begin
                n_checks++;
                if ({busy_a, done_a, tmo_a} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL tmo_sticky_idle: got %b expected 001", {busy_a, done_a, tmo_a});
                end
                beg_a = 1'b1;
            end
            step();
        end
        beg_a = 1'b0; op_done = 1'b1;
        n_checks++;
        if ({en_a, addr_a, busy_a, tmo_a} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_restart_clear: got %b expected 1000010", {en_a, addr_a, busy_a, tmo_a});
        end
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done_a === 1'b1) begin
                done_cyc = c;
                break;
            end
            step();
        end
        n_checks++;
        if (done_cyc != 21 || tmo_a !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_rerun: done cycle %0d tmo %b expected 21 and 0", done_cyc, tmo_a);
        end
        op_done = 1'b0;
        step();
        step();
    endtask

    // ITER=1, TMO=3: op_done on OP_WAIT cycle k; k=4 runs out the watchdog.
    task automatic test_iter1(input int k);
        int   done_cyc;
        logic exp_tmo;
        int   exp_cyc;
        exp_tmo = (k > 3);
        exp_cyc = (k > 3) ? 7 : 5 + k;
        beg_c = 1'b1; op_done = 1'b0;
        step();
        beg_c = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            op_done = (c == 3 + k);
            if (done_c === 1'b1 && done_cyc == 0) done_cyc = c;
            step();
        end
        op_done = 1'b0;
        n_checks++;
        if (done_cyc != exp_cyc || tmo_c !== exp_tmo || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL iter1_k%0d: done cycle %0d tmo %b busy %b expected %0d %b 0",
                     k, done_cyc, tmo_c, busy_c, exp_cyc, exp_tmo);
        end
    endtask

    task automatic test_iter32();
        int         done_cyc;
        logic [4:0] prev, max_addr;
        bit         wrap;
        beg_b = 1'b1; op_done = 1'b1;
        step();
        beg_b = 1'b0;
        done_cyc = 0; prev = 5'd0; max_addr = 5'd0; wrap = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (en_b === 1'b1) begin
                if (addr_b < prev) wrap = 1'b1;
                prev = addr_b;
                if (addr_b > max_addr) max_addr = addr_b;
            end
            if (done_b === 1'b1) begin
                done_cyc = c;
                break;
            end
            step();
        end
        op_done = 1'b0;
        step();
        n_checks++;
        if (done_cyc != 161) begin
            n_fail++;
            $display("FAIL iter32_done_cycle: got %0d expected 161", done_cyc);
        end
        n_checks++;
        if (max_addr !== 5'd31 || wrap) begin
            n_fail++;
            $display("FAIL iter32_addr: max %0d wrap %0d expected 31 0", max_addr, wrap);
        end
    endtask

    // Iteration 5 (i=4) reaches OP_WAIT in cycle 24; rst is applied there.
    task automatic test_reset_mid_run();
        bit bad;
        beg_b = 1'b1; op_done = 1'b1; sign_z = 1'b0;
        step();
        beg_b = 1'b0;
        for (int c = 1; c <= 23; c++) step();
        op_done = 1'b0;
        n_checks++;
        if ({en_b, addr_b, busy_b, ops_b, dir_b} !== {1'b1, 5'd4, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrun_pre: got %b expected 100100101", {en_b, addr_b, busy_b, ops_b, dir_b});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({obs_b, dir_b} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected 0000", {obs_b, dir_b});
        end
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done_b !== 1'b0 || busy_b !== 1'b0) bad = 1'b1;
            step();
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL midrun_no_done: got done/busy activity expected none");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ignored_inputs();
        test_timeout();
        test_iter1(1);
        test_iter1(3);
        test_iter1(4);
        test_iter32();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
